nemo_inert_intf: RTL and testbench
==================================

Name: nemo_inert_intf

Overview:
- Owns the SPI link between the KnightsTour digital core and the NEMO inertial sensor.
- After reset it waits a power-up interval, then writes the NEMO configuration registers. Completion is flagged on `init_done`; the physics model's `NEMO_setup` rises at this point.
- It then services every `INT` assertion by reading yaw-rate low and high bytes and presents a 16-bit signed `yaw_rt` with a one-cycle `vld` strobe.
- Sits between the NEMO pins and the heading/PID path that drives the motor PWM.

Parameters:
- INIT_WAIT_W, 16, width of the power-up wait counter; the wait ends when the counter rolls over (2^INIT_WAIT_W clocks).
- SCLK_DIV_W, 4, width of the SCLK divider; SCLK period is 2^SCLK_DIV_W clocks (16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- SS_n  out  1  SPI serf select, active low
- SCLK  out  1  SPI clock, idle high
- MOSI  out  1  SPI data to NEMO, MSB first
- MISO  in  1  SPI data from NEMO
- INT  in  1  NEMO data-ready, asynchronous, active high
- init_done  out  1  high once all config writes have completed; stays high
- yaw_rt  out  16  signed yaw rate, {yawH, yawL}
- vld  out  1  one-cycle strobe when `yaw_rt` updates

Behaviour:
- Reset values: SS_n=1, SCLK=1, MOSI=0, init_done=0, yaw_rt=0, vld=0. The wait counter and the state machine clear.
- INT handling: double-flopped to `INT_ff2` before any use.
- SPI frame (all transactions):
  - 16 bits, mode 3 style. Data shifts on SCLK fall; MISO is sampled on SCLK rise.
  - SS_n falls at `wrt`. The first SCLK fall occurs half a period later.
  - SS_n rises one half-period after the 16th rise.
  - `done` pulses for one clk when SS_n rises.
  - Read data is the low 8 bits of the 16-bit shift register.
- State machine:
  - INIT_WAIT: count until rollover, then go to CFG0.
  - CFG0 (0x0D02, INT enable) -> CFG1 (0x1053, accel) -> CFG2 (0x1150, gyro) -> CFG3 (0x1460, rounding). Each state issues one `wrt` and waits for `done`.
  - After CFG3 `done`: set init_done and go to IDLE.
  - IDLE: on `INT_ff2`=1, issue 0xA600 (yawL read) and go to RD_L.
  - RD_L: on `done`, latch the low byte into the yawL holding register, issue 0xA700 and go to RD_H.
  - RD_H: on `done`, load `yaw_rt` = {rx[7:0], yawL}, pulse `vld`, return to IDLE.
- Latency: `vld` asserts on the clk after the RD_H `done` pulse.
- `yaw_rt` holds between updates.
- INT still high on return to IDLE starts a new read immediately.
- INT pulses during RD_L/RD_H are not queued.
- INT before init_done is ignored.
- A `wrt` is never issued while a frame is in flight.
- Reset mid-frame: outputs return to reset values immediately; init restarts from INIT_WAIT.

Optional Feature:
- Macro: YAW_OFFSET_CAL_EN.
- Defined:
  - Adds output `cal_done` (1 bit) and an internal 16-bit `yaw_off` register.
  - The first 16 valid readings after init_done are summed into 20 bits.
  - `yaw_off` = sum>>>4.
  - `yaw_rt` then reports raw − `yaw_off`, saturated to 16-bit signed.
  - `vld` is suppressed during calibration; `cal_done` rises after the 16th reading.
- Undefined: no `cal_done` port; raw yaw is passed through.

Decomposition:
- Package `nemo_pkg`:
  - state enum `nemo_state_t`;
  - localparam command words NEMO_CFG_INT, NEMO_CFG_ACC, NEMO_CFG_GYRO, NEMO_CFG_RND, NEMO_RD_YAWL, NEMO_RD_YAWH.
- Sub-module `spi_mnrch`: ports clk, rst_n, wrt, wt_data[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO. It owns the divider, bit counter and shift register.
- `nemo_inert_intf` instantiates one `spi_mnrch` and holds the main state machine.

Test Plan:
- Reset release with INT=0:
  - SS_n, SCLK stay 1 for 65536 clocks.
  - Four frames follow, carrying 0x0D02, 0x1053, 0x1150, 0x1460 in that order.
  - init_done rises within 600 clocks of the 4th SS_n fall; the NEMO model `NEMO_setup` rises.
- After init, model yaw = 0x12F4, INT pulsed:
  - frames 0xA600 then 0xA700;
  - `vld` is high for exactly one clk;
  - `yaw_rt` = 0x12F4.
- Negative yaw 0xFF38 (−200) → `yaw_rt` = 0xFF38; `$signed` check equals −200.
- INT held high continuously → back-to-back read pairs; no gap larger than 2 clocks between SS_n rise and the next SS_n fall.
- rst_n asserted mid-CFG2 frame → SS_n=1, init_done=0 within 1 clk; after release the full init sequence repeats from CFG0.
- YAW_OFFSET_CAL_EN, constant raw 0x0010:
  - no `vld` for 16 readings;
  - `cal_done` rises after the 16th reading;
  - the next `yaw_rt` = 0x0000.

Source files
------------

// File: rtl/nemo_pkg.sv
// nemo_pkg: shared types and constants for the NEMO inertial sensor interface.
//   nemo_state_t : main sequencer states (power-up wait, four config writes,
//                  idle, yaw low/high reads)
//   NEMO_*       : 16-bit SPI command words ({addr, data})
//   sat_sub16    : signed 16-bit a-b, clamped to the 16-bit signed range
package nemo_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT = 4'd0,
    ST_CFG0      = 4'd1,
    ST_CFG1      = 4'd2,
    ST_CFG2      = 4'd3,
    ST_CFG3      = 4'd4,
    ST_IDLE      = 4'd5,
    ST_RD_L      = 4'd6,
    ST_RD_H      = 4'd7
  } nemo_state_t;

  localparam logic [15:0] NEMO_CFG_INT  = 16'h0D02;  // data-ready interrupt enable
  localparam logic [15:0] NEMO_CFG_ACC  = 16'h1053;  // accel setup
  localparam logic [15:0] NEMO_CFG_GYRO = 16'h1150;  // gyro setup
  localparam logic [15:0] NEMO_CFG_RND  = 16'h1460;  // rounding mode
  localparam logic [15:0] NEMO_RD_YAWL  = 16'hA600;  // read yaw rate low byte
  localparam logic [15:0] NEMO_RD_YAWH  = 16'hA700;  // read yaw rate high byte

  function automatic logic [15:0] sat_sub16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    // Overflow shows as the sign-extension bit disagreeing with bit 15.
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

endpackage

// File: rtl/nemo_inert_intf_spi_mnrch.sv
// spi_mnrch: 16-bit SPI monarch, mode 3 (SCLK idles high).
//   clk, rst_n    : clock, async active-low reset
//   wrt, wt_data  : start a frame carrying wt_data (ignored while a frame runs)
//   done          : one-clk pulse coincident with SS_n rising
//   rd_data       : 16 bits captured from MISO, MSB first
//   SS_n/SCLK/MOSI/MISO : SPI pins
// SCLK period is 2^DIV_W clocks. The first falling edge comes half a period
// after SS_n falls; MOSI changes on falls, MISO is sampled on rises.
module spi_mnrch #(
  parameter int DIV_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  // div value on the last clk of the high / low phase of SCLK
  localparam logic [DIV_W-1:0] DIV_HALF = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_LAST = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic             ss_n_q,  ss_n_d;
  logic             sclk_q,  sclk_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [4:0]       bit_q,   bit_d;
  logic [15:0]      shft_q,  shft_d;
  logic             miso_q,  miso_d;
  logic             first_q, first_d;
  logic             done_q,  done_d;

  always_comb begin
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    miso_d  = miso_q;
    first_d = first_q;
    done_d  = 1'b0;
    if (ss_n_q) begin
      if (wrt) begin
        ss_n_d  = 1'b0;
        sclk_d  = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        shft_d  = wt_data;
        first_d = 1'b1;
      end
    end else begin
      div_d = div_q + DIV_ONE;
      if (div_q == DIV_HALF) begin
        if (bit_q == 5'd16) begin
          // Where the 17th fall would be: close the frame and shift in the
          // bit sampled on the 16th rise.
          ss_n_d = 1'b1;
          sclk_d = 1'b1;
          shft_d = {shft_q[14:0], miso_q};
          done_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          first_d = 1'b0;
          // The first fall must not shift: bit 15 has not been sampled yet.
          if (!first_q) shft_d = {shft_q[14:0], miso_q};
        end
      end else if (div_q == DIV_LAST) begin
        sclk_d = 1'b1;
        miso_d = MISO;
        bit_d  = bit_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      div_q   <= '0;
      bit_q   <= '0;
      shft_q  <= '0;
      miso_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
      miso_q  <= miso_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = ~ss_n_q & shft_q[15];
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

// File: rtl/nemo_inert_intf.sv
// nemo_inert_intf: SPI link to the NEMO inertial sensor.
//   clk, rst_n      : clock, async active-low reset
//   SS_n/SCLK/MOSI/MISO : SPI pins to NEMO
//   INT             : NEMO data-ready (asynchronous, synchronized here)
//   init_done       : config writes complete (sticky until reset)
//   yaw_rt, vld     : signed yaw rate {yawH, yawL} and its one-clk strobe
//   cal_done        : only with YAW_OFFSET_CAL_EN; offset calibration finished
// After a 2^INIT_WAIT_W clock power-up wait, four config words are written,
// then each INT triggers a yawL/yawH read pair.
// Optional macro YAW_OFFSET_CAL_EN: the first 16 readings are averaged into
// a zero offset that is then subtracted (saturating) from every reading;
// vld stays low until calibration finishes.
module nemo_inert_intf
  import nemo_pkg::*;
#(
  parameter int INIT_WAIT_W = 16,
  parameter int SCLK_DIV_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  input  logic        INT,
  output logic        init_done,
  output logic [15:0] yaw_rt,
  output logic        vld
`ifdef YAW_OFFSET_CAL_EN
  ,
  output logic        cal_done
`endif
);

  localparam logic [INIT_WAIT_W-1:0] WAIT_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

  nemo_state_t            state_q, state_d;
  logic [INIT_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]             yawl_q, yawl_d;
  logic [15:0]            yaw_q, yaw_d;
  logic                   vld_q, vld_d;
  logic                   init_done_q, init_done_d;
  logic                   int_ff1_q, int_ff2_q;  // int_ff2_q is INT_ff2

  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [15:0] raw;
  logic        rd_hi_unused;

`ifdef YAW_OFFSET_CAL_EN
  logic [3:0]  cal_cnt_q, cal_cnt_d;
  logic [19:0] cal_sum_q, cal_sum_d;
  logic [15:0] yaw_off_q, yaw_off_d;
  logic        cal_done_q, cal_done_d;
`endif

  spi_mnrch #(.DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .wt_data (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // Only the data byte of a read frame matters; the upper byte is the
  // sensor's don't-care during address shift-out.
  assign rd_hi_unused = ^rd_data[15:8];
  assign raw          = {rd_data[7:0], yawl_q};

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    yawl_d      = yawl_q;
    yaw_d       = yaw_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    wrt         = 1'b0;
    cmd         = NEMO_CFG_INT;
`ifdef YAW_OFFSET_CAL_EN
    cal_cnt_d   = cal_cnt_q;
    cal_sum_d   = cal_sum_q;
    yaw_off_d   = yaw_off_q;
    cal_done_d  = cal_done_q;
`endif
    // Every wrt below is issued either from INIT_WAIT/IDLE (SPI idle) or on
    // the done pulse, when SS_n has just risen, so frames never overlap.
    case (state_q)
      ST_INIT_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
        if (&wait_cnt_q) begin
          wrt     = 1'b1;
          cmd     = NEMO_CFG_INT;
          state_d = ST_CFG0;
        end
      end
      ST_CFG0: if (done) begin
        wrt     = 1'b1;
        cmd     = NEMO_CFG_ACC;
        state_d = ST_CFG1;
      end
      ST_CFG1: if (done) begin
        wrt     = 1'b1;
        cmd     = NEMO_CFG_GYRO;
        state_d = ST_CFG2;
      end
      ST_CFG2: if (done) begin
        wrt     = 1'b1;
        cmd     = NEMO_CFG_RND;
        state_d = ST_CFG3;
      end
      ST_CFG3: if (done) begin
        init_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_IDLE: if (int_ff2_q) begin
        wrt     = 1'b1;
        cmd     = NEMO_RD_YAWL;
        state_d = ST_RD_L;
      end
      ST_RD_L: if (done) begin
        yawl_d  = rd_data[7:0];
        wrt     = 1'b1;
        cmd     = NEMO_RD_YAWH;
        state_d = ST_RD_H;
      end
      ST_RD_H: if (done) begin
        state_d = ST_IDLE;
`ifdef YAW_OFFSET_CAL_EN
        if (!cal_done_q) begin
          cal_sum_d = cal_sum_q + {{4{raw[15]}}, raw};
          cal_cnt_d = cal_cnt_q + 4'd1;
          if (cal_cnt_q == 4'hF) begin
            cal_done_d = 1'b1;
            yaw_off_d  = cal_sum_d[19:4];  // arithmetic >>4 of the 20-bit sum
          end
        end else begin
          yaw_d = sat_sub16(raw, yaw_off_q);
          vld_d = 1'b1;
        end
`else
        yaw_d = raw;
        vld_d = 1'b1;
`endif
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT_WAIT;
      wait_cnt_q  <= '0;
      yawl_q      <= '0;
      yaw_q       <= '0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      int_ff1_q   <= 1'b0;
      int_ff2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      yawl_q      <= yawl_d;
      yaw_q       <= yaw_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      int_ff1_q   <= INT;
      int_ff2_q   <= int_ff1_q;
    end
  end

`ifdef YAW_OFFSET_CAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_q  <= '0;
      cal_sum_q  <= '0;
      yaw_off_q  <= '0;
      cal_done_q <= 1'b0;
    end else begin
      cal_cnt_q  <= cal_cnt_d;
      cal_sum_q  <= cal_sum_d;
      yaw_off_q  <= yaw_off_d;
      cal_done_q <= cal_done_d;
    end
  end
  assign cal_done = cal_done_q;
`endif

  assign init_done = init_done_q;
  assign yaw_rt    = yaw_q;
  assign vld       = vld_q;

endmodule

// File: tb/tb_nemo_inert_intf.sv
// Bench for nemo_inert_intf with a behavioural NEMO sensor model that decodes
// whole SPI frames and answers yaw reads from yaw_model.
module tb_nemo_inert_intf;

  localparam int INIT_W = 10;

  logic        clk, rst_n, INT, miso_r;
  logic        SS_n, SCLK, MOSI, init_done, vld;
  logic [15:0] yaw_rt;
`ifdef YAW_OFFSET_CAL_EN
  logic        cal_done;
`endif

  nemo_inert_intf #(.INIT_WAIT_W(INIT_W), .SCLK_DIV_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (miso_r),
    .INT       (INT),
    .init_done (init_done),
    .yaw_rt    (yaw_rt),
    .vld       (vld)
`ifdef YAW_OFFSET_CAL_EN
    ,
    .cal_done  (cal_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0, nfail = 0, ntot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- NEMO sensor model ----------------
  logic [15:0] yaw_model;
  logic        gap_en;
  logic [15:0] frames[$];
  logic [15:0] vq[$];
  logic [15:0] rx;
  logic [7:0]  addr_r;
  logic        sclk_p = 1'b1, ssn_p = 1'b1, vld_p = 1'b0;
  int          nb = 0, cyc = 0, last_fall = 0, vld_long = 0;
  int          gap = 0, gap_max = 0, cfg_ix = 0;
  logic        nemo_setup;

  function automatic logic [15:0] cfg_word(input int i);
    case (i)
      0: return 16'h0D02;
      1: return 16'h1053;
      2: return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic nemo_bit(input logic [7:0] addr, input int i);
    logic [7:0] b;
    b = (addr == 8'hA6) ? yaw_model[7:0] : (addr == 8'hA7) ? yaw_model[15:8] : 8'h00;
    return b[3'(15 - i)];
  endfunction

  assign nemo_setup = (cfg_ix == 4);

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sclk_p <= SCLK;
    ssn_p  <= SS_n;
    vld_p  <= vld;
    if (ssn_p && !SS_n) begin
      nb        <= 0;
      last_fall <= cyc;
      miso_r    <= 1'b0;
    end
    if (!SS_n && !sclk_p && SCLK) begin
      rx <= {rx[14:0], MOSI};
      nb <= nb + 1;
    end
    if (!SS_n && sclk_p && !SCLK) begin
      if (nb == 8) addr_r <= rx[7:0];
      if (nb >= 8 && nb < 16) miso_r <= nemo_bit((nb == 8) ? rx[7:0] : addr_r, nb);
      else miso_r <= 1'b0;
    end
    // Only complete 16-bit frames count; a reset-aborted frame is dropped.
    if (!ssn_p && SS_n && nb == 16) begin
      frames.push_back(rx);
      if (cfg_ix < 4 && rx == cfg_word(cfg_ix)) cfg_ix <= cfg_ix + 1;
    end
    if (vld) vq.push_back(yaw_rt);
    if (vld && vld_p) vld_long <= vld_long + 1;
    if (!gap_en) begin
      gap <= 0; gap_max <= 0;
    end else if (SS_n) gap <= gap + 1;
    else begin
      if (gap > gap_max) gap_max <= gap;
      gap <= 0;
    end
  end

  // Expected reported yaw for a raw sensor value.
  function automatic logic [15:0] exp_yaw(input logic [15:0] y);
`ifdef YAW_OFFSET_CAL_EN
    int d;
    d = int'($signed(y)) - 16;  // offset learned from constant 0x0010
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
`else
    return y;
`endif
  endfunction

  task automatic pulse_int();
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] y, input string tag);
    int n0, f0, k;
    logic [15:0] got;
    yaw_model = y;
    n0 = vq.size();
    f0 = frames.size();
    pulse_int();
    k = 0;
    while (vq.size() == n0 && k < 2000) begin @(negedge clk); k++; end
    chk({tag, "_tmo"}, 32'(k < 2000), 1);
    chk({tag, "_frL"}, (frames.size() > f0) ? frames[f0] : 16'hxxxx, 16'hA600);
    chk({tag, "_frH"}, (frames.size() > f0 + 1) ? frames[f0 + 1] : 16'hxxxx, 16'hA700);
    got = (vq.size() > n0) ? vq[n0] : 16'hxxxx;
    chk({tag, "_yaw"}, got, exp_yaw(y));
    repeat (20) @(negedge clk);
    chk({tag, "_hold"}, yaw_rt, exp_yaw(y));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, lat, n0, base;
    logic [15:0] y;
    rst_n = 1'b0; INT = 1'b0; yaw_model = '0; gap_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ssn", SS_n, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_yaw", yaw_rt, 0);
    chk("rst_vld", vld, 0);

    // Power-up wait: SS_n held high for 2^INIT_W clocks after release.
    rst_n = 1'b1;
    k = 0;
    while (SS_n && k < 5000) begin @(negedge clk); k++; end
    chk("init_wait_clks", k, 2 ** INIT_W);

    k = 0;
    while (!init_done && k < 3000) begin @(negedge clk); k++; end
    chk("init_done_tmo", 32'(k < 3000), 1);
    lat = cyc - last_fall;
    chk("init_done_lat", 32'(lat > 0 && lat <= 600), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("cfg%0d", i), (frames.size() > i) ? frames[i] : 16'hxxxx, cfg_word(i));
    chk("nemo_setup", nemo_setup, 1);

`ifdef YAW_OFFSET_CAL_EN
    yaw_model = 16'h0010;
    n0 = vq.size();
    for (int r = 0; r < 16; r++) begin
      base = frames.size();
      pulse_int();
      k = 0;
      while (frames.size() < base + 2 && k < 2000) begin @(negedge clk); k++; end
      repeat (4) @(negedge clk);
      if (r == 14) chk("cal_not_done", cal_done, 0);
    end
    chk("cal_no_vld", vq.size(), n0);
    chk("cal_done", cal_done, 1);
    do_read(16'h0010, "cal_zero");
`endif

    do_read(16'h12F4, "yaw_pos");
    do_read(16'hFF38, "yaw_neg");
`ifndef YAW_OFFSET_CAL_EN
    chk("yaw_neg_signed", 32'($signed(yaw_rt) == -200), 1);
`endif
    for (int r = 0; r < 8; r++) begin
      y = 16'($urandom_range(0, 65535));
      do_read(y, $sformatf("rnd%0d", r));
    end
    chk("vld_one_clk", vld_long, 0);

    // INT held high: reads run back to back.
    yaw_model = 16'($urandom_range(0, 65535));
    n0 = vq.size();
    INT = 1'b1;
    k = 0;
    while (vq.size() < n0 + 1 && k < 2000) begin @(negedge clk); k++; end
    gap_en = 1'b1;
    while (vq.size() < n0 + 4 && k < 5000) begin @(negedge clk); k++; end
    chk("held_tmo", 32'(k < 5000), 1);
    chk("held_gap", 32'(gap_max <= 2), 1);
    for (int i = 1; i < 4; i++)
      chk($sformatf("held_yaw%0d", i), (vq.size() > n0 + i) ? vq[n0 + i] : 16'hxxxx, exp_yaw(yaw_model));
    gap_en = 1'b0;
    INT = 1'b0;
    repeat (1200) @(negedge clk);
    chk("held_vld_one_clk", vld_long, 0);

    // Reset while init_done is high, then again in the middle of CFG2;
    // INT is held high throughout so pre-init INT is exercised too.
    rst_n = 1'b0;
    #1;
    chk("rst1_init_done", init_done, 0);
    @(negedge clk);
    base = frames.size();
    rst_n = 1'b1;
    INT = 1'b1;
    k = 0;
    while (!(frames.size() == base + 2 && !SS_n) && k < 5000) begin @(negedge clk); k++; end
    chk("cfg2_reach_tmo", 32'(k < 5000), 1);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midfrm_ssn", SS_n, 1);
    chk("midfrm_sclk", SCLK, 1);
    chk("midfrm_init_done", init_done, 0);
    @(negedge clk);
    base = frames.size();
    rst_n = 1'b1;
    k = 0;
    while (!init_done && k < 5000) begin @(negedge clk); k++; end
    chk("reinit_tmo", 32'(k < 5000), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("recfg%0d", i), (frames.size() > base + i) ? frames[base + i] : 16'hxxxx, cfg_word(i));
    k = 0;
    while (frames.size() < base + 5 && k < 1000) begin @(negedge clk); k++; end
    chk("reinit_first_read", (frames.size() > base + 4) ? frames[base + 4] : 16'hxxxx, 16'hA600);
    INT = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
